// File: rtl/data_memory_bank_pkg.sv
// Shared definitions for the data memory bank.
// Contents: clear-FSM state encoding, the byte width, and a helper that
// derives the number of byte lanes from the data width.
package data_memory_bank_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

  localparam int unsigned BYTE = 8;

  // Number of byte lanes for a data width (width must be a multiple of BYTE).
  function automatic int unsigned calc_bw(input int unsigned dw);
    return dw / BYTE;
  endfunction

endpackage

// File: rtl/data_memory_bank_mem_clear_fsm.sv
// Clear sequencer for the data memory bank: sweeps every row to zero after
// reset or on request, one row per cycle.
// Ports:
//   i_clk      clock, rising edge
//   i_rst      synchronous active-high reset (starts a fresh sweep)
//   i_clr      request a sweep (honoured only while idle)
//   o_busy     sweep in progress (decoded from state)
//   o_clr_we   zero the row at o_clr_idx this cycle
//   o_clr_idx  row being cleared
module mem_clear_fsm
  import data_memory_bank_pkg::*;
#(
  parameter int unsigned AW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  state_t        r_state;
  logic [AW-1:0] r_idx;
  state_t        w_state_nxt;
  logic [AW-1:0] w_idx_nxt;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic; a clr seen during a sweep is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (i_clr) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Outputs; no row is zeroed on a reset edge, the sweep starts after it.
  always_comb begin
    o_busy    = (r_state == ST_CLEAR);
    o_clr_we  = (r_state == ST_CLEAR) && !i_rst;
    o_clr_idx = r_idx;
  end

endmodule

// File: rtl/data_memory_bank.sv
// Parametrised single-port data memory with per-byte write enables, a
// registered read with valid strobe, and a zeroing sweep after reset or clr.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   en, we     access request; we=1 write, we=0 read
//   be         byte-lane write enables
//   addr, din  row address and write data
//   clr        request a full-array clear
//   dout       registered read data (holds between reads)
//   rd_valid   one-cycle strobe, dout valid
//   busy       clear sweep in progress
//   acc_err    one-cycle strobe, access rejected while busy
module data_memory_bank
  import data_memory_bank_pkg::*;
#(
  parameter  int unsigned AW = 5,
  parameter  int unsigned DW = 32,
  localparam int unsigned BW = calc_bw(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [BW-1:0] be,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          busy,
  output logic          acc_err
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;
  logic          r_rd_valid;
  logic          r_acc_err;

  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_idx;
  logic          w_rd;
  logic          w_wr;

  mem_clear_fsm #(
    .AW (AW)
  ) u_clear_fsm (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (clr),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_idx (w_clr_idx)
  );

  // Accesses only proceed while idle; a same-cycle clr does not block them.
  assign w_rd = en && !we && !w_busy;
  assign w_wr = en &&  we && !w_busy && !rst;

  // Storage: sweep writes and user writes are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < int'(BW); i++) begin
        if (be[i]) begin
          r_mem[addr][i*BYTE +: BYTE] <= din[i*BYTE +: BYTE];
        end
      end
    end
  end

  // Read register and status strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
      r_acc_err  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      r_acc_err  <= en && w_busy;
      if (w_rd) begin
        r_dout <= r_mem[addr];
      end
    end
  end

  assign dout     = r_dout;
  assign rd_valid = r_rd_valid;
  assign acc_err  = r_acc_err;
  assign busy     = w_busy;

endmodule
